// File: rtl/fb_pkg.sv
// Shared framebuffer constants, render FSM state type and the fb_addr packing helper.
package fb_pkg;

    localparam int FB_H_RES = 640;
    localparam int FB_V_RES = 480;
    localparam int FB_PIX_W = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        DRAW_KICK = 2'd2,
        DRAW      = 2'd3
    } render_state_t;

    // Packs {buffer_sel, pixel_addr}; the caller narrows the result to ADDR_W+1 bits.
    function automatic logic [31:0] fb_pack_addr(input logic sel, input logic [30:0] addr,
                                                 input int unsigned aw);
        return ({31'd0, sel} << aw) | {1'b0, addr};
    endfunction

endpackage

// File: rtl/fb_clear_cnt.sv
// Clear address counter: walks 0..N-1 once per start, holding the address currently issued.
module fb_clear_cnt #(
    parameter int ADDR_W = 19,
    parameter int N      = 307200
) (
    input  logic              clk_sys,
    input  logic              srst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_next
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    // Load on start, then step once per cycle and stop at the terminal address.
    always_ff @(posedge clk_sys or negedge srst_n) begin
        if (!srst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == LAST_ADDR) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_cnt  <= r_cnt;
            r_busy <= r_busy;
        end
    end

    assign o_busy = r_busy;
    assign o_last = r_busy && (r_cnt == LAST_ADDR);
    assign o_next = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/render_sequencer.sv
// Back-buffer render sequencer owning the framebuffer write port.
// Define RENDER_SEQ_CLEAR_EN to clear each frame to bg_color before drawing.
module render_sequencer
    import fb_pkg::*;
#(
    parameter int H_RES  = FB_H_RES,
    parameter int V_RES  = FB_V_RES,
    parameter int PIX_W  = FB_PIX_W,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk_sys,
    input  logic              srst_n,
    input  logic              start_render,
    input  logic              back_sel,
    input  logic [PIX_W-1:0]  bg_color,
    output logic              render_idle,
    output logic              draw_start,
    output logic              draw_gnt,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [PIX_W-1:0]  draw_data,
    input  logic              draw_done,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_addr,
    output logic [PIX_W-1:0]  fb_wdata,
    output logic              overrun,
    output logic [15:0]       oob_cnt
);

    localparam int unsigned N = H_RES * V_RES;

    render_state_t     r_state;
    render_state_t     w_state_nx;
    logic              r_sel;
    logic              w_we_nx;
    logic [ADDR_W:0]   w_addr_nx;
    logic [PIX_W-1:0]  w_wdata_nx;
    logic              w_accept;
    logic              w_in_range;
    logic              w_draw_oob;

    assign w_accept   = (r_state == IDLE) && start_render;
    assign w_in_range = 32'(draw_addr) < N;
    assign w_draw_oob = (r_state == DRAW) && draw_req && !w_in_range;

`ifdef RENDER_SEQ_CLEAR_EN
    logic [PIX_W-1:0]  r_bg;
    logic              w_clr_busy;
    logic              w_clr_last;
    logic [ADDR_W-1:0] w_clr_next;

    fb_clear_cnt #(.ADDR_W(ADDR_W), .N(N)) u_clear_cnt (
        .clk_sys (clk_sys),
        .srst_n  (srst_n),
        .i_start (w_accept),
        .o_busy  (w_clr_busy),
        .o_last  (w_clr_last),
        .o_next  (w_clr_next)
    );
`else
    logic w_unused_bg;
    assign w_unused_bg = ^bg_color;
`endif

    // Next state and next framebuffer write; the port is granted purely by state.
    always_comb begin
        w_state_nx = r_state;
        w_we_nx    = 1'b0;
        w_addr_nx  = fb_addr;
        w_wdata_nx = fb_wdata;
        case (r_state)
            IDLE: begin
                if (start_render) begin
`ifdef RENDER_SEQ_CLEAR_EN
                    w_state_nx = CLEAR;
                    w_we_nx    = 1'b1;
                    w_addr_nx  = (ADDR_W+1)'(fb_pack_addr(back_sel, 31'd0, ADDR_W));
                    w_wdata_nx = bg_color;
`else
                    w_state_nx = DRAW_KICK;
`endif
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CLEAR: begin
`ifdef RENDER_SEQ_CLEAR_EN
                if (w_clr_busy && !w_clr_last) begin
                    w_we_nx    = 1'b1;
                    w_addr_nx  = (ADDR_W+1)'(fb_pack_addr(r_sel, 31'(w_clr_next), ADDR_W));
                    w_wdata_nx = r_bg;
                end else begin
                    w_state_nx = DRAW_KICK;
                end
`else
                w_state_nx = IDLE;
`endif
            end
            DRAW_KICK: w_state_nx = DRAW;
            DRAW: begin
                if (draw_req && w_in_range) begin
                    w_we_nx    = 1'b1;
                    w_addr_nx  = (ADDR_W+1)'(fb_pack_addr(r_sel, 31'(draw_addr), ADDR_W));
                    w_wdata_nx = draw_data;
                end else begin
                    w_we_nx = 1'b0;
                end
                if (draw_done) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = DRAW;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, latched frame parameters and all registered outputs.
    always_ff @(posedge clk_sys or negedge srst_n) begin
        if (!srst_n) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            render_idle <= 1'b1;
            draw_start  <= 1'b0;
            draw_gnt    <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            overrun     <= 1'b0;
            oob_cnt     <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            render_idle <= (w_state_nx == IDLE);
            draw_start  <= (w_state_nx == DRAW_KICK);
            draw_gnt    <= (w_state_nx == DRAW);
            fb_we       <= w_we_nx;
            fb_addr     <= w_addr_nx;
            fb_wdata    <= w_wdata_nx;
            overrun     <= start_render && (r_state != IDLE);
            if (w_accept) begin
                r_sel <= back_sel;
            end
            if (w_draw_oob && (oob_cnt != 16'hFFFF)) begin
                oob_cnt <= oob_cnt + 16'd1;
            end
        end
    end

`ifdef RENDER_SEQ_CLEAR_EN
    // Clear colour is captured together with the buffer select.
    always_ff @(posedge clk_sys or negedge srst_n) begin
        if (!srst_n) begin
            r_bg <= '0;
        end else if (w_accept) begin
            r_bg <= bg_color;
        end else begin
            r_bg <= r_bg;
        end
    end
`endif

endmodule
